// File: rtl/uart_pkg.sv
// Shared types and parameter checks for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit counter must reach DATA_W-1 (at most 8) and STOP_BITS-1.
  localparam int BIT_CNT_W = 4;

  // True when every transmitter parameter lies inside its legal range.
  function automatic bit params_ok(input int data_w, input int clks_per_bit,
                                   input int parity, input int stop_bits,
                                   input int fifo_depth);
    params_ok = (data_w >= 4) && (data_w <= 9) &&
                (clks_per_bit >= 1) && (clks_per_bit <= 65535) &&
                (parity >= int'(PAR_NONE)) && (parity <= int'(PAR_ODD)) &&
                (stop_bits >= 1) && (stop_bits <= 2) &&
                (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word-input handshake of the UART transmitter.
// Handshake: a word moves from master to slave on every clk edge where
// tx_valid && tx_ready. tx_ready never depends on tx_valid in the same
// cycle. Once tx_valid is raised the master holds tx_valid and tx_data
// stable until the transfer edge.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Requests are ignored when they would overflow or underflow.
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Pointer and count next-state; pointers wrap modulo DEPTH naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset flushes every buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, with a programmable clocks-per-bit divider.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_frame_if.slave              bus,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output tx_state_e                   state_dbg
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  if (!params_ok(DATA_W, CLKS_PER_BIT, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_frame: parameter outside legal range");
  end

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      fifo_head;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   fifo_empty, push, pop;
  logic                   baud_tick, last_data, last_stop;

  // Ready comes from the registered count only, never from tx_valid.
  assign bus.tx_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push         = bus.tx_valid && bus.tx_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus.tx_data),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign baud_tick = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_q == BIT_CNT_W'(DATA_W - 1));
  assign last_stop = (bit_q == BIT_CNT_W'(STOP_BITS - 1));

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: the end of the last stop bit chains straight into a new start bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (baud_tick) state_d = ST_DATA;
      ST_DATA:   if (baud_tick && last_data) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_tick) state_d = ST_STOP;
      ST_STOP:   if (baud_tick && last_stop) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counters, shift register, FIFO pop and the next tx level, all derived
  // from the next state so tx is registered yet aligned with state entry.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    pop     = (state_d == ST_START) && (state_q != ST_START);

    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      baud_d = '0;
      bit_d  = '0;
    end else if (baud_tick) begin
      baud_d = '0;
      bit_d  = bit_q + BIT_CNT_W'(1);
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    if (pop) begin
      shift_d = fifo_head;
      par_d   = (PARITY == int'(PAR_ODD)) ? ~^fifo_head : ^fifo_head;
    end else if ((state_q == ST_DATA) && (state_d == ST_DATA) && baud_tick) begin
      shift_d = shift_q >> 1;
    end

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign state_dbg = state_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the serial-IO subsystem: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO and serialises each as a full asynchronous frame. The frame has a start bit, DATA_W data bits sent LSB first, an optional parity bit, and 1 or 2 stop bits. A programmable baud divider sets the bit period. The block is the generalised successor of the fixed 4-bit, one-clock-per-bit transmitter and drives the pad-side `tx` line directly.

## Interface
Parameters:
- DATA_W, 8: data bits per frame; legal range 4..9.
- CLKS_PER_BIT, 4: clocks per bit period; legal range 1..65535.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  `tx_data` is valid this cycle.
- tx_ready  out  1  FIFO can accept a word this cycle.
- tx_data  in  DATA_W  word to transmit.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- Reset values: tx=1, tx_busy=0, fifo_count=0, tx_ready=1; FSM in IDLE; baud and bit counters at 0.
- Handshake: a word is accepted on any clk edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count < FIFO_DEPTH), taken from registered count; no combinational path from tx_valid.
  - tx_valid with tx_ready low: the word is not accepted, and the source holds it.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE, or → START if the FIFO is non-empty.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for one bit period.
  - DATA: shift out DATA_W bits, LSB first; the bit counter runs 0..DATA_W-1.
  - PARITY: tx = ^data for even parity, ~^data for odd parity, so the count of 1s over data+parity is even (even) or odd (odd).
  - STOP: tx=1 for STOP_BITS bit periods.
- Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit or state on terminal count. It is reset on every state entry. Width is $clog2(CLKS_PER_BIT+1).
- tx is a registered output, so no glitches.
- Simultaneous push and pop: fifo_count is unchanged, and both operations take effect.
  - When full, a pop does not raise tx_ready in the same cycle, because ready comes from the registered count.
- Pointer wrap-around: natural modulo FIFO_DEPTH.
- Reset mid-frame aborts the frame: tx=1 on the next edge and the FIFO is flushed. Buffered words are discarded.

## Timing
- Frame length F = (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency, with FSM idle and FIFO empty:
  - Word accepted at edge E.
  - FSM pops at edge E+1; tx is low from E+1.
- Back-to-back words: the next start bit begins on the edge immediately after the last stop-bit period ends, with zero idle cycles.
- tx_busy rises at edge E (FIFO non-empty). It falls on the edge that returns the FSM to IDLE with the FIFO empty.
- fifo_count updates on the edge of the push or pop.

## Structure
- Package `uart_pkg`:
  - `parity_e` (NONE, EVEN, ODD).
  - `tx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - Elaboration checks on legal parameter ranges.
- Sub-module `uart_sync_fifo`, parametrised on width and depth, providing push/pop/count. The top level contains the FSM, baud counter, shift register and parity logic.

## Test plan
- Reset then idle: 20 cycles with no stimulus → tx=1, tx_busy=0, fifo_count=0, tx_ready=1 throughout.
- Single frame, defaults: push 8'hA5 → tx, sampled mid-bit every 4 cycles, reads 0,1,0,1,0,0,1,0,1,1. Frame length 40 cycles; tx_busy drops at the end.
- Parity: PARITY=1, DATA_W=7, word 7'h55 → parity bit 0; PARITY=2 → parity bit 1. STOP_BITS=2 → stop is high for 2×CLKS_PER_BIT.
- FIFO full and back-pressure: FIFO_DEPTH=4, push 6 words with tx_valid held → tx_ready low after the 4th word is buffered. Words 5 and 6 are accepted only as slots free. All 6 frames go out back-to-back with no idle cycle between them, in order.
- Simultaneous push/pop at full: push on the cycle the FSM pops → fifo_count stays 4 and tx_ready stays 0 that cycle.
- Reset mid-frame: assert rst during the DATA bit 3 with 2 words queued → tx=1 and fifo_count=0 on the next edge. No further frames are sent.
